// File: rtl/instruction_fetch_buffer.sv
// instruction_fetch_buffer: IF-stage instruction-memory master.
// Issues one read per fetch on a valid/ready address channel and accepts the
// returned word on a valid/ready data channel. bus_stall holds the pipeline
// while a fetch is outstanding, and the instruction/past_instruction pair keeps
// the word seen by decode stable across bus and hazard stalls.
// Optional feature macro: FETCH_ERR_EN adds a response code input (im_rresp)
// and a one-cycle fetch_err pulse. An errored word is replaced by NOP_INST.
module instruction_fetch_buffer #(
    parameter int                   DATA_SIZE = 32,
    parameter int                   ADDR_SIZE = 32,
    parameter logic [DATA_SIZE-1:0] NOP_INST  = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] pc_in,
    input  logic                 fetch_en,
    input  logic                 instruction_stall,
    output logic                 im_req_valid,
    output logic [ADDR_SIZE-1:0] im_req_addr,
    input  logic                 im_req_ready,
    input  logic [DATA_SIZE-1:0] im_rdata,
    input  logic                 im_rvalid,
    output logic                 im_rready,
`ifdef FETCH_ERR_EN
    input  logic [1:0]           im_rresp,
    output logic                 fetch_err,
`endif
    output logic [DATA_SIZE-1:0] instruction,
    output logic [DATA_SIZE-1:0] past_instruction,
    output logic                 bus_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    logic   start;
    logic   resp_err;

    assign start = fetch_en && !instruction_stall;

`ifdef FETCH_ERR_EN
    assign resp_err = (im_rresp != 2'b00);
`else
    assign resp_err = 1'b0;
`endif

    // Channel handshakes follow directly from the registered state.
    assign im_req_valid = (state == ADDR);
    assign im_rready    = (state == DATA);

    // Hold the pipeline from the start cycle until the word is accepted.
    // The reset term keeps the stall low while rst is asserted.
    assign bus_stall = !rst && (((state == IDLE) && start) ||
                                (state == ADDR) ||
                                ((state == DATA) && !im_rvalid));

    // Fetch FSM: latch the address on start, wait for ready, then wait for data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            im_req_addr <= '0;
            instruction <= NOP_INST;
`ifdef FETCH_ERR_EN
            fetch_err   <= 1'b0;
`endif
        end else begin
`ifdef FETCH_ERR_EN
            fetch_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        im_req_addr <= pc_in;
                        state       <= ADDR;
                    end
                end
                ADDR: begin
                    // Address and valid stay put until the bus takes them.
                    if (im_req_ready) state <= DATA;
                end
                DATA: begin
                    if (im_rvalid) begin
                        // Data is accepted even under a hazard stall.
                        instruction <= resp_err ? NOP_INST : im_rdata;
`ifdef FETCH_ERR_EN
                        fetch_err   <= resp_err;
`endif
                        if (start) begin
                            // Chain straight into the next fetch, no idle bubble.
                            im_req_addr <= pc_in;
                            state       <= ADDR;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // past_instruction only advances on cycles where the pipeline moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            past_instruction <= NOP_INST;
        else if (!instruction_stall && !bus_stall)
            past_instruction <= instruction;
    end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Directed testbench for instruction_fetch_buffer: a table of per-cycle
// input/expected-output records, plus hand-written reset-mid-fetch and
// (with FETCH_ERR_EN) error-response sequences.
module tb_instruction_fetch_buffer;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        fetch_en;
    logic        instruction_stall;
    logic        im_req_valid;
    logic [31:0] im_req_addr;
    logic        im_req_ready;
    logic [31:0] im_rdata;
    logic        im_rvalid;
    logic        im_rready;
    logic [31:0] instruction;
    logic [31:0] past_instruction;
    logic        bus_stall;
`ifdef FETCH_ERR_EN
    logic [1:0]  im_rresp;
    logic        fetch_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instruction_fetch_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .pc_in            (pc_in),
        .fetch_en         (fetch_en),
        .instruction_stall(instruction_stall),
        .im_req_valid     (im_req_valid),
        .im_req_addr      (im_req_addr),
        .im_req_ready     (im_req_ready),
        .im_rdata         (im_rdata),
        .im_rvalid        (im_rvalid),
        .im_rready        (im_rready),
`ifdef FETCH_ERR_EN
        .im_rresp         (im_rresp),
        .fetch_err        (fetch_err),
`endif
        .instruction      (instruction),
        .past_instruction (past_instruction),
        .bus_stall        (bus_stall)
    );

    typedef struct {
        // inputs for the cycle
        logic        fe;
        logic        hs;
        logic [31:0] pc;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        // outputs expected just before the closing clock edge
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_rr;
        logic        e_bs;
        logic [31:0] e_ins;
        logic [31:0] e_past;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fe, logic hs, logic [31:0] pc, logic rdy,
                                logic rv, logic [31:0] rd, logic e_rqv,
                                logic [31:0] e_addr, logic e_rr, logic e_bs,
                                logic [31:0] e_ins, logic [31:0] e_past);
        vec_t v;
        v.fe = fe; v.hs = hs; v.pc = pc; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_rr = e_rr; v.e_bs = e_bs;
        v.e_ins = e_ins; v.e_past = e_past;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rqv, input logic [31:0] addr,
                            input logic rr, input logic bs, input logic [31:0] ins,
                            input logic [31:0] past);
        chk({tag, ".im_req_valid"}, {31'd0, im_req_valid}, {31'd0, rqv});
        chk({tag, ".im_req_addr"}, im_req_addr, addr);
        chk({tag, ".im_rready"}, {31'd0, im_rready}, {31'd0, rr});
        chk({tag, ".bus_stall"}, {31'd0, bus_stall}, {31'd0, bs});
        chk({tag, ".instruction"}, instruction, ins);
        chk({tag, ".past_instruction"}, past_instruction, past);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Idle after reset
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,32'h0,0,0,32'h0, 0,32'h0,0,0,NOP,NOP));
        // Single fetch at 0x40
        vecs.push_back(mk(1,0,32'h40,0,0,32'h0,        0,32'h0 ,0,1,NOP,NOP));
        vecs.push_back(mk(0,0,32'h40,1,0,32'h0,        1,32'h40,0,1,NOP,NOP));
        vecs.push_back(mk(0,0,32'h40,0,1,32'h00A00093, 0,32'h40,1,0,NOP,NOP));
        vecs.push_back(mk(0,0,32'h40,0,0,32'h0,        0,32'h40,0,0,32'h00A00093,NOP));
        vecs.push_back(mk(0,0,32'h40,0,0,32'h0,        0,32'h40,0,0,32'h00A00093,32'h00A00093));
        // Backpressure: ready low 3 cycles, rvalid on 4th DATA cycle; pc changes ignored
        vecs.push_back(mk(1,0,32'h100,0,0,32'h0, 0,32'h40 ,0,1,32'h00A00093,32'h00A00093));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,32'h200,0,0,32'h0, 1,32'h100,0,1,32'h00A00093,32'h00A00093));
        vecs.push_back(mk(0,0,32'h200,1,0,32'h0, 1,32'h100,0,1,32'h00A00093,32'h00A00093));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,32'h200,0,0,32'h0, 0,32'h100,1,1,32'h00A00093,32'h00A00093));
        vecs.push_back(mk(0,0,32'h200,0,1,32'h12345678, 0,32'h100,1,0,32'h00A00093,32'h00A00093));
        vecs.push_back(mk(0,0,32'h200,0,0,32'h0, 0,32'h100,0,0,32'h12345678,32'h00A00093));
        // Back-to-back fetches 0x0, 0x4, 0x8
        vecs.push_back(mk(1,0,32'h0,0,0,32'h0,        0,32'h100,0,1,32'h12345678,32'h12345678));
        vecs.push_back(mk(1,0,32'h4,1,0,32'h0,        1,32'h0  ,0,1,32'h12345678,32'h12345678));
        vecs.push_back(mk(1,0,32'h4,0,1,32'h11111111, 0,32'h0  ,1,0,32'h12345678,32'h12345678));
        vecs.push_back(mk(1,0,32'h8,1,0,32'h0,        1,32'h4  ,0,1,32'h11111111,32'h12345678));
        vecs.push_back(mk(1,0,32'h8,0,1,32'h22222222, 0,32'h4  ,1,0,32'h11111111,32'h12345678));
        vecs.push_back(mk(1,0,32'h8,1,0,32'h0,        1,32'h8  ,0,1,32'h22222222,32'h11111111));
        vecs.push_back(mk(0,0,32'h8,0,1,32'h33333333, 0,32'h8  ,1,0,32'h22222222,32'h11111111));
        vecs.push_back(mk(0,0,32'h8,0,0,32'h0,        0,32'h8  ,0,0,32'h33333333,32'h22222222));
        // Hazard overlapping data return
        vecs.push_back(mk(1,0,32'h300,0,0,32'h0,        0,32'h8  ,0,1,32'h33333333,32'h33333333));
        vecs.push_back(mk(0,0,32'h300,1,0,32'h0,        1,32'h300,0,1,32'h33333333,32'h33333333));
        vecs.push_back(mk(1,1,32'h400,0,1,32'hDEADBEEF, 0,32'h300,1,0,32'h33333333,32'h33333333));
        vecs.push_back(mk(1,1,32'h400,0,0,32'h0,        0,32'h300,0,0,32'hDEADBEEF,32'h33333333));
        vecs.push_back(mk(0,0,32'h400,0,0,32'h0,        0,32'h300,0,0,32'hDEADBEEF,32'h33333333));
        vecs.push_back(mk(0,0,32'h400,0,0,32'h0,        0,32'h300,0,0,32'hDEADBEEF,32'hDEADBEEF));
        // Stray rvalid in IDLE and ADDR must be ignored
        vecs.push_back(mk(0,0,32'h400,0,1,32'hCAFECAFE, 0,32'h300,0,0,32'hDEADBEEF,32'hDEADBEEF));
        vecs.push_back(mk(1,0,32'h500,0,0,32'h0,        0,32'h300,0,1,32'hDEADBEEF,32'hDEADBEEF));
        vecs.push_back(mk(0,0,32'h500,0,1,32'h55555555, 1,32'h500,0,1,32'hDEADBEEF,32'hDEADBEEF));
        vecs.push_back(mk(0,0,32'h500,1,0,32'h0,        1,32'h500,0,1,32'hDEADBEEF,32'hDEADBEEF));
        vecs.push_back(mk(0,0,32'h500,0,1,32'h66666666, 0,32'h500,1,0,32'hDEADBEEF,32'hDEADBEEF));
        vecs.push_back(mk(0,0,32'h500,0,0,32'h0,        0,32'h500,0,0,32'h66666666,32'hDEADBEEF));

        // Reset asserted with a fetch request present: no stall while in reset
        rst = 1'b1; fetch_en = 1'b1; instruction_stall = 1'b0; pc_in = 32'h40;
        im_req_ready = 1'b0; im_rvalid = 1'b0; im_rdata = 32'h0;
`ifdef FETCH_ERR_EN
        im_rresp = 2'b00;
`endif
        #2;
        chk_outs("reset", 0, 32'h0, 0, 0, NOP, NOP);
`ifdef FETCH_ERR_EN
        chk("reset.fetch_err", {31'd0, fetch_err}, 32'd0);
`endif
        tick();
        fetch_en = 1'b0;
        rst = 1'b0;

        // Table-driven cycles
        for (int i = 0; i < vecs.size(); i++) begin
            fetch_en          = vecs[i].fe;
            instruction_stall = vecs[i].hs;
            pc_in             = vecs[i].pc;
            im_req_ready      = vecs[i].rdy;
            im_rvalid         = vecs[i].rv;
            im_rdata          = vecs[i].rd;
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vecs[i].e_rqv, vecs[i].e_addr, vecs[i].e_rr,
                     vecs[i].e_bs, vecs[i].e_ins, vecs[i].e_past);
            tick();
        end
        fetch_en = 1'b0; im_req_ready = 1'b0; im_rvalid = 1'b0;

        // Reset mid-fetch: abandon in DATA, late rvalid dropped in IDLE
        fetch_en = 1'b1; pc_in = 32'h600;
        tick();
        fetch_en = 1'b0; im_req_ready = 1'b1;
        tick();
        im_req_ready = 1'b0;
        chk("midrst.in_data", {31'd0, im_rready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outs("midrst", 0, 32'h0, 0, 0, NOP, NOP);
        tick();
        rst = 1'b0;
        im_rvalid = 1'b1; im_rdata = 32'hBAD0BAD0;
        #1;
        chk("midrst.late_rready", {31'd0, im_rready}, 32'd0);
        tick();
        im_rvalid = 1'b0;
        chk("midrst.late_ins", instruction, NOP);
        chk("midrst.late_rready2", {31'd0, im_rready}, 32'd0);

`ifdef FETCH_ERR_EN
        // Error response replaces the word with NOP and pulses fetch_err once
        fetch_en = 1'b1; pc_in = 32'h700;
        tick();
        fetch_en = 1'b0; im_req_ready = 1'b1;
        tick();
        im_req_ready = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h77777777; im_rresp = 2'b10;
        @(negedge clk);
        chk("err.before", {31'd0, fetch_err}, 32'd0);
        tick();
        im_rvalid = 1'b0; im_rresp = 2'b00;
        chk("err.ins", instruction, NOP);
        chk("err.pulse", {31'd0, fetch_err}, 32'd1);
        tick();
        chk("err.clear", {31'd0, fetch_err}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_buffer.md
Name: instruction_fetch_buffer

Overview:
- CPU-side instruction-memory master for the IF stage.
- Issues one read per fetch over a valid/ready address channel and accepts the returned word on a valid/ready data channel.
- Generates bus_stall while a fetch is outstanding.
- Maintains the instruction/past_instruction pair consumed by the pipeline's stall-select logic, so the decode stage sees a stable word across bus and hazard stalls.

Parameters:
DATA_SIZE, 32, instruction/data word width
ADDR_SIZE, 32, fetch address width
NOP_INST, 32'h00000013, value of instruction/past_instruction after reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
pc_in  input  ADDR_SIZE  fetch address from PC register
fetch_en  input  1  IF stage requests the word at pc_in
instruction_stall  input  1  pipeline hazard stall from hazard unit
im_req_valid  output  1  address channel valid
im_req_addr  output  ADDR_SIZE  address channel address (registered)
im_req_ready  input  1  address channel ready from bus
im_rdata  input  DATA_SIZE  returned instruction word
im_rvalid  input  1  data channel valid
im_rready  output  1  data channel ready
instruction  output  DATA_SIZE  most recently fetched word (registered)
past_instruction  output  DATA_SIZE  word presented on the last non-stalled cycle (registered)
bus_stall  output  1  fetch outstanding, pipeline must hold

Behaviour:
- States: IDLE, ADDR, DATA. 2-bit state register.
- Reset (async, immediate on rst=1):
  - state=IDLE, im_req_addr=0, instruction=NOP_INST, past_instruction=NOP_INST.
  - im_req_valid=0, im_rready=0, bus_stall=0 while rst=1.
- start = fetch_en && !instruction_stall.
- IDLE:
  - if start: im_req_addr<=pc_in, go ADDR.
  - else stay.
- ADDR:
  - im_req_valid=1, im_req_addr stable.
  - On im_req_ready: go DATA.
  - Valid never drops before ready. instruction_stall and pc_in changes are ignored here.
- DATA:
  - im_rready=1.
  - On im_rvalid: instruction<=im_rdata.
    - If start: im_req_addr<=pc_in, go ADDR (back-to-back, no IDLE bubble).
    - Else go IDLE.
  - Data is accepted even if instruction_stall=1.
- im_rready=1 only in DATA. Any im_rvalid seen in IDLE or ADDR is ignored and does not update instruction.
- bus_stall is combinational and equals (IDLE&&start) || ADDR || (DATA&&!im_rvalid).
- Minimum fetch latency, with ready and rvalid each high on the first eligible cycle:
  - start cycle → ADDR cycle → DATA cycle with rvalid.
  - instruction valid on the cycle after the rvalid edge.
  - bus_stall high for 2 cycles.
- past_instruction<=instruction on every cycle with instruction_stall=0 && bus_stall=0. Otherwise it holds.
- Simultaneous instruction_stall and im_rvalid in DATA: instruction updates, past_instruction holds, return to IDLE.
- Reset mid-fetch: transaction is abandoned. The bus is expected to be reset by the same rst; late rvalid is dropped in IDLE.
- No address arithmetic in this block. pc_in is used verbatim; alignment is the PC logic's responsibility.

Optional Feature:
- Macro FETCH_ERR_EN.
- Defined:
  - Adds input im_rresp [1:0] and output fetch_err (registered, 1 bit, reset 0).
  - On DATA accept with im_rresp!=2'b00: instruction<=NOP_INST instead of im_rdata, and fetch_err=1 for exactly one cycle.
  - State transitions are unchanged.
- Undefined:
  - No extra ports.
  - Responses are always treated as OKAY; im_rdata is always captured.

Test Plan:
- Reset then idle: rst pulse, fetch_en=0 for 5 cycles → instruction=past_instruction=32'h00000013, im_req_valid=0, bus_stall=0 throughout.
- Single fetch: pc_in=32'h0000_0040, fetch_en=1 one cycle, ready and rvalid same cycle they become eligible, im_rdata=32'h00A00093 → im_req_addr=0x40 in ADDR, bus_stall high 2 cycles, instruction=32'h00A00093 next cycle, past_instruction=32'h00A00093 one cycle later.
- Bus backpressure: im_req_ready low 3 cycles, then rvalid delayed 4 cycles → im_req_valid and im_req_addr stable all 3 cycles, bus_stall high 8 cycles total, past_instruction unchanged during stall.
- Back-to-back: fetch_en held at 1, pc_in 0x0,0x4,0x8 with data 0x11111111/0x22222222/0x33333333 → DATA→ADDR with no IDLE cycle, instruction sequence matches, im_req_addr 0x0,0x4,0x8.
- Hazard overlap: instruction_stall=1 while in DATA when rvalid arrives with 0xDEADBEEF → instruction=0xDEADBEEF, past_instruction holds old value until first cycle with both stalls low, next fetch not started while instruction_stall=1.
- Reset mid-fetch: rst asserted in DATA, then rvalid=1 with 0xBAD0BAD0 after release → state IDLE, im_rready=0, instruction=32'h00000013. With FETCH_ERR_EN defined, im_rresp=2'b10 on accept → instruction=NOP_INST and fetch_err a single-cycle pulse.
